gate_truth_sequencer: RTL

Self-checking stimulus stage placed directly upstream of the two-input NAND/NOR gate block. It drives the gate's `a`/`b` inputs through all four input vectors and holds each for a programmable number of cycles. At the end of each hold it samples the gate's `y1` (NAND) and `y2` (NOR) outputs against expected values, then reports per-vector errors and an overall pass flag through a start/done handshake.

---
 rtl/gate_test_pkg.sv | 20 ++
 rtl/hold_timer.sv | 23 ++
 rtl/gate_truth_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and reference gate functions for the NAND/NOR truth-table sequencer.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 4;

  function automatic logic exp_nand(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic exp_nor(input logic a, input logic b);
    return ~(a | b);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Per-vector hold counter; tick marks the last cycle of a hold (the sample cycle).
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clear) cnt <= '0;
    else            cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == CW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/gate_truth_sequencer.sv
// Sweeps {a,b} through 00..11, samples the gate's NAND/NOR outputs at the end of
// each hold, and reports per-vector errors plus a pass flag via start/done.
module gate_truth_sequencer
  import gate_test_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y1,
  input  logic       y2,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask
);

  state_t     state, state_nxt;
  logic       tick, sample, clear, mismatch, last_vec;
  logic [3:0] err_nxt;

  // Counter is held at zero outside DRIVE so the first vector gets a full hold.
  assign clear = (state != DRIVE) || tick || abort;

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick (tick)
  );

  assign sample   = (state == DRIVE) && tick && !abort;
  assign last_vec = (vec_idx == 2'(NUM_VECTORS - 1));
  assign mismatch = (y1 != exp_nand(a, b)) || (y2 != exp_nor(a, b));

  always_comb begin
    err_nxt = err_mask;
    if (sample && mismatch) err_nxt[vec_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE: begin
        if (abort)                    state_nxt = IDLE;
        else if (sample && last_vec)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRIVE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx  <= '0;
      err_mask <= '0;
      pass     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            vec_idx  <= '0;
            err_mask <= '0;
            pass     <= 1'b0;
          end
        end
        DRIVE: begin
          // Abort keeps partial error bits and wins over a coincident sample.
          if (abort) begin
            vec_idx <= '0;
          end else if (sample) begin
            err_mask <= err_nxt;
            if (last_vec) begin
              vec_idx <= '0;
              pass    <= (err_nxt == 4'b0000);
            end else begin
              vec_idx <= vec_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign a = vec_idx[1];
  assign b = vec_idx[0];

endmodule
